// File: rtl/dl_fpu_pkg.sv
// Shared definitions for the DLFloat16 FPU issue path: unit enable codes,
// exception encodings and the in-flight tracker entry.
package dl_fpu_pkg;

  localparam logic [3:0] ENA_IDLE = 4'b0000;
  localparam logic [3:0] ENA_ADD  = 4'b0001;
  localparam logic [3:0] ENA_SUB  = 4'b0010;
  localparam logic [3:0] ENA_MUL  = 4'b0011;
  localparam logic [3:0] ENA_DIV  = 4'b0100;
  localparam logic [3:0] ENA_SIGN = 4'b0101;

  localparam logic [4:0] EXC_INVALID = 5'b00001;

  // Wide enough for the largest supported port count (4).
  localparam int ID_W = 2;

  typedef struct packed {
    logic            valid;
    logic            bypass;
    logic [ID_W-1:0] id;
  } trk_entry_t;

  function automatic logic ena_is_legal(input logic [3:0] ena);
    return (ena >= ENA_ADD) && (ena <= ENA_SIGN);
  endfunction

endpackage

// File: rtl/fpu_issue_sched_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, the first eligible
// requester wins, and the pointer moves past the winner on accept.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     eligible_i,
  input  logic             accept_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    int idx;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    // Walk from the farthest offset down so the nearest eligible port wins.
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(ptr_q) + off) % N;
      if (eligible_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      ptr_d = (grant_idx_o == IDX_W'(N - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fpu_issue_sched.sv
// Issue scheduler for the shared DLFloat16 FPU: arbitrates requester ports,
// drives the registered FPU bus and routes results back after LAT edges.
module fpu_issue_sched
  import dl_fpu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_ena,
  input  logic [2*NREQ-1:0]    req_sel,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [16*NREQ-1:0]   rsp_data,
  output logic [5*NREQ-1:0]    rsp_exc,
  output logic [3:0]           fpu_ena,
  output logic [1:0]           fpu_sel,
  output logic [15:0]          fpu_in1,
  output logic [15:0]          fpu_in2,
  input  logic [15:0]          fpu_out,
  input  logic [4:0]           fpu_exc
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  busy_q, busy_d;
  logic [NREQ-1:0]  eligible, grant;
  logic [IDX_W-1:0] grant_idx;
  logic             accept;

  logic [3:0]  sel_ena;
  logic [1:0]  sel_sel;
  logic [15:0] sel_a, sel_b;
  logic        sel_legal;

  logic [3:0]  fpu_ena_q, fpu_ena_d;
  logic [1:0]  fpu_sel_q, fpu_sel_d;
  logic [15:0] fpu_in1_q, fpu_in1_d;
  logic [15:0] fpu_in2_q, fpu_in2_d;

  trk_entry_t trk_q [LAT+1];
  trk_entry_t trk_d [LAT+1];
  trk_entry_t trk_out;

  logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0][15:0] rsp_data_q, rsp_data_d;
  logic [NREQ-1:0][4:0]  rsp_exc_q, rsp_exc_d;

  assign eligible = req_valid & ~busy_q;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .eligible_i (eligible),
    .accept_i   (accept),
    .grant_o    (grant),
    .grant_idx_o(grant_idx)
  );

  // A grant only exists for a valid request, so any grant is a handshake.
  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    sel_ena = ENA_IDLE;
    sel_sel = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_ena = req_ena[i*4 +: 4];
        sel_sel = req_sel[i*2 +: 2];
        sel_a   = req_a[i*16 +: 16];
        sel_b   = req_b[i*16 +: 16];
      end
    end
  end

  assign sel_legal = ena_is_legal(sel_ena);

  // The enable is a one-cycle strobe; operands and select simply hold.
  always_comb begin
    fpu_ena_d = ENA_IDLE;
    fpu_sel_d = fpu_sel_q;
    fpu_in1_d = fpu_in1_q;
    fpu_in2_d = fpu_in2_q;
    if (accept && sel_legal) begin
      fpu_ena_d = sel_ena;
      fpu_sel_d = sel_sel;
      fpu_in1_d = sel_a;
      fpu_in2_d = sel_b;
    end
  end

  always_comb begin
    trk_d[0] = '0;
    if (accept) begin
      trk_d[0] = '{valid: 1'b1, bypass: ~sel_legal, id: ID_W'(grant_idx)};
    end
    for (int s = 1; s <= LAT; s++) trk_d[s] = trk_q[s-1];
  end

  assign trk_out = trk_q[LAT];

  always_comb begin
    busy_d      = (busy_q | grant) & ~(rsp_valid_q & rsp_ready);
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    rsp_exc_d   = rsp_exc_q;
    for (int i = 0; i < NREQ; i++) begin
      if (trk_out.valid && trk_out.id == ID_W'(i)) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = trk_out.bypass ? 16'h0000 : fpu_out;
        rsp_exc_d[i]   = trk_out.bypass ? EXC_INVALID : fpu_exc;
      end
    end
  end

  // NOTE: the tracker is a tiny shift register whose valid bits must clear, so it is reset like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      fpu_ena_q   <= ENA_IDLE;
      fpu_sel_q   <= '0;
      fpu_in1_q   <= '0;
      fpu_in2_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_exc_q   <= '0;
      for (int s = 0; s <= LAT; s++) trk_q[s] <= '0;
    end else begin
      busy_q      <= busy_d;
      fpu_ena_q   <= fpu_ena_d;
      fpu_sel_q   <= fpu_sel_d;
      fpu_in1_q   <= fpu_in1_d;
      fpu_in2_q   <= fpu_in2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_exc_q   <= rsp_exc_d;
      for (int s = 0; s <= LAT; s++) trk_q[s] <= trk_d[s];
    end
  end

  assign fpu_ena   = fpu_ena_q;
  assign fpu_sel   = fpu_sel_q;
  assign fpu_in1   = fpu_in1_q;
  assign fpu_in2   = fpu_in2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_exc   = rsp_exc_q;

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Self-checking bench for fpu_issue_sched: an FPU model with fixed latency,
// per-port scoreboard queues and directed scenarios.
module tb_fpu_issue_sched;

  localparam int NREQ = 2;
  localparam int LAT  = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [4*NREQ-1:0]   req_ena;
  logic [2*NREQ-1:0]   req_sel;
  logic [16*NREQ-1:0]  req_a, req_b;
  logic [NREQ-1:0]     rsp_valid, rsp_ready;
  logic [16*NREQ-1:0]  rsp_data;
  logic [5*NREQ-1:0]   rsp_exc;
  logic [3:0]          fpu_ena;
  logic [1:0]          fpu_sel;
  logic [15:0]         fpu_in1, fpu_in2, fpu_out;
  logic [4:0]          fpu_exc;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fpu_issue_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_ena  (req_ena),
    .req_sel  (req_sel),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_exc  (rsp_exc),
    .fpu_ena  (fpu_ena),
    .fpu_sel  (fpu_sel),
    .fpu_in1  (fpu_in1),
    .fpu_in2  (fpu_in2),
    .fpu_out  (fpu_out),
    .fpu_exc  (fpu_exc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Arbitrary but deterministic FPU behaviour; idle returns all-ones.
  function automatic logic [20:0] fpu_model(input logic [3:0] ena, input logic [1:0] sel,
                                            input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [4:0]  x;
    r = 16'hFFFF;
    x = 5'h1F;
    case (ena)
      4'b0001: begin r = a + b;                 x = 5'b00100; end
      4'b0010: begin r = a - b;                 x = 5'b01000; end
      4'b0011: begin r = a ^ {b[7:0], b[15:8]}; x = 5'b00010; end
      4'b0100: begin r = {a[7:0], b[15:8]};     x = 5'b10000; end
      4'b0101: begin
        x = {3'b000, sel};
        case (sel)
          2'b00:   r = a ^ 16'h8000;
          2'b01:   r = {1'b0, a[14:0]};
          2'b10:   r = {b[15], a[14:0]};
          default: r = a;
        endcase
      end
      default: ;
    endcase
    return {x, r};
  endfunction

  logic [20:0] fpu_pipe [LAT];
  always @(posedge clk) begin
    fpu_pipe[0] <= fpu_model(fpu_ena, fpu_sel, fpu_in1, fpu_in2);
    for (int s = 1; s < LAT; s++) fpu_pipe[s] <= fpu_pipe[s-1];
  end
  assign fpu_out = fpu_pipe[LAT-1][15:0];
  assign fpu_exc = fpu_pipe[LAT-1][20:16];

  // Scoreboard and monitor, sampled on the falling edge.
  logic [20:0]     exp_q [NREQ][$];
  int              cyc = 0;
  int              hs_cyc [NREQ];
  int              hs_count [NREQ];
  logic [NREQ-1:0] prev_rv = '0;
  logic            check_alt = 1'b0;
  int              last_hs_port = -1;
  logic [1:0]      last_sel = '0;
  logic [15:0]     last_a = '0, last_b = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) exp_q[i].delete();
      prev_rv  = '0;
      last_sel = '0;
      last_a   = '0;
      last_b   = '0;
    end else begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          logic [3:0] e;
          e = req_ena[i*4 +: 4];
          if (e >= 4'd1 && e <= 4'd5) begin
            exp_q[i].push_back(fpu_model(e, req_sel[i*2 +: 2], req_a[i*16 +: 16], req_b[i*16 +: 16]));
            last_sel = req_sel[i*2 +: 2];
            last_a   = req_a[i*16 +: 16];
            last_b   = req_b[i*16 +: 16];
          end else begin
            exp_q[i].push_back({5'b00001, 16'h0000});
          end
          hs_cyc[i] = cyc;
          hs_count[i]++;
          if (check_alt && last_hs_port >= 0) check("rr_alternate", i, 1 - last_hs_port);
          last_hs_port = i;
        end
        if (rsp_valid[i] && !prev_rv[i]) check("rsp_latency", cyc, hs_cyc[i] + LAT + 2);
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            logic [20:0] ex;
            ex = exp_q[i].pop_front();
            check("rsp_data", rsp_data[i*16 +: 16], ex[15:0]);
            check("rsp_exc", rsp_exc[i*5 +: 5], ex[20:16]);
          end
        end
      end
      prev_rv = rsp_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [3:0] ena, input logic [1:0] sel,
                         input logic [15:0] a, input logic [15:0] b);
    req_valid[p]       = v;
    req_ena[p*4 +: 4]  = ena;
    req_sel[p*2 +: 2]  = sel;
    req_a[p*16 +: 16]  = a;
    req_b[p*16 +: 16]  = b;
  endtask

  task automatic wait_rsp(input int p, input int max_cycles);
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge clk);
      if (rsp_valid[p]) return;
    end
    check("wait_rsp_timeout", 0, 1);
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    repeat (8) step();
  endtask

  initial begin
    int p1_before;
    logic [15:0] snap_d;
    logic [4:0]  snap_e;

    rst = 1'b1;
    req_valid = '0; req_ena = '0; req_sel = '0; req_a = '0; req_b = '0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) begin hs_cyc[i] = 0; hs_count[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and idle behaviour.
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_exc", rsp_exc, 0);
    check("rst_fpu_ena", fpu_ena, 0);
    check("rst_fpu_sel", fpu_sel, 0);
    check("rst_fpu_in1", fpu_in1, 0);
    check("rst_fpu_in2", fpu_in2, 0);
    check("rst_req_ready", req_ready, 0);
    for (int n = 0; n < 3; n++) begin
      step();
      check("idle_fpu_ena", fpu_ena, 0);
      check("idle_req_ready", req_ready, 0);
    end

    // Single SIGN op on port 0.
    set_req(0, 1'b1, 4'b0101, 2'b00, 16'h3C00, 16'h0000);
    @(negedge clk);
    check("single_ready", req_ready, 2'b01);
    step();
    req_valid[0] = 1'b0;
    check("single_fpu_ena", fpu_ena, 4'b0101);
    check("single_fpu_in1", fpu_in1, 16'h3C00);
    check("single_fpu_sel", fpu_sel, 2'b00);
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("busy_ready0_a", req_ready[0], 0);
    step();
    check("single_ena_idle", fpu_ena, 4'b0000);
    check("single_no_rsp_yet", rsp_valid[0], 0);
    check("busy_ready0_b", req_ready[0], 0);
    step();
    check("single_rsp_valid", rsp_valid[0], 1);
    check("single_rsp_data", rsp_data[15:0], 16'hBC00);
    check("busy_ready0_c", req_ready[0], 0);
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    step();
    rsp_ready[0] = 1'b0;
    check("single_rsp_cleared", rsp_valid[0], 0);

    // Both ports requesting every cycle: grants must alternate.
    rsp_ready = '1;
    last_hs_port = -1;
    check_alt = 1'b1;
    p1_before = hs_count[0] + hs_count[1];
    for (int c = 0; c < 24; c++) begin
      for (int p = 0; p < NREQ; p++)
        set_req(p, 1'b1, 4'($urandom_range(1, 5)), 2'($urandom_range(0, 3)),
                16'($urandom), 16'($urandom));
      step();
    end
    req_valid = '0;
    check_alt = 1'b0;
    check("alt_issue_count", 32'((hs_count[0] + hs_count[1] - p1_before) >= 10), 1);
    drain();

    // Illegal enable on port 1 is answered locally.
    rsp_ready = '0;
    set_req(1, 1'b1, 4'b1010, 2'b11, 16'h1234, 16'h5678);
    @(negedge clk);
    check("illegal_ready", req_ready, 2'b10);
    step();
    req_valid[1] = 1'b0;
    check("illegal_fpu_ena", fpu_ena, 4'b0000);
    check("illegal_fpu_sel", fpu_sel, last_sel);
    check("illegal_fpu_in1", fpu_in1, last_a);
    check("illegal_fpu_in2", fpu_in2, last_b);
    step();
    check("illegal_no_rsp_yet", rsp_valid[1], 0);
    step();
    check("illegal_rsp_valid", rsp_valid[1], 1);
    check("illegal_rsp_data", rsp_data[31:16], 16'h0000);
    check("illegal_rsp_exc", rsp_exc[9:5], 5'b00001);
    rsp_ready[1] = 1'b1;
    step();
    rsp_ready[1] = 1'b0;

    // Port 0 response stalled while port 1 keeps issuing.
    set_req(0, 1'b1, 4'b0001, 2'b00, 16'h1111, 16'h2222);
    step();
    wait_rsp(0, 10);
    snap_d = 16'h3333;
    snap_e = 5'b00100;
    rsp_ready = 2'b10;
    p1_before = hs_count[1];
    for (int c = 0; c < 5; c++) begin
      set_req(1, 1'b1, 4'($urandom_range(1, 5)), 2'($urandom_range(0, 3)),
              16'($urandom), 16'($urandom));
      step();
      @(negedge clk);
      check("stall_rsp_valid0", rsp_valid[0], 1);
      check("stall_rsp_data0", rsp_data[15:0], snap_d);
      check("stall_rsp_exc0", rsp_exc[4:0], snap_e);
      check("stall_ready0", req_ready[0], 0);
    end
    check("stall_port1_issued", 32'((hs_count[1] - p1_before) >= 1), 1);
    drain();

    // Reset with two operations in flight.
    rsp_ready = '0;
    req_valid = 2'b11;
    step();
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", rsp_valid, 0);
      check("post_rst_fpu_ena", fpu_ena, 0);
      check("post_rst_req_ready", req_ready, 0);
      step();
    end
    set_req(1, 1'b1, 4'b0010, 2'b00, 16'h0040, 16'h0004);
    #1 check("post_rst_port1_free", req_ready, 2'b10);
    set_req(0, 1'b1, 4'b0011, 2'b00, 16'h00FF, 16'h0F0F);
    #1 check("post_rst_ptr0_prio", req_ready, 2'b01);
    step();
    drain();

    for (int i = 0; i < NREQ; i++) check("sb_empty", 32'(exp_q[i].size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
